// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer wrapped around an external n-bit ALU: small register file, carry flag, debug read port.
// Optional build macro ALU_SEQ_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module alu_op_sequencer #(
  parameter  int n    = 8,
  parameter  int REGS = 8,
  localparam int AW   = ($clog2(REGS) < 2) ? 2 : $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  output logic [n-1:0]  alu_r2,
  output logic [n-1:0]  alu_r3,
  output logic [2:0]    alu_op,
  input  logic [n-1:0]  alu_r1,
  input  logic          alu_c_out,
  input  logic          alu_c_out2,
  output logic          done,
  output logic [AW-1:0] done_rd,
  output logic [n-1:0]  done_data,
  output logic          illegal,
  output logic          carry,
  input  logic [AW-1:0] dbg_addr,
  output logic [n-1:0]  dbg_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t          state;
  logic [n-1:0]    rf [REGS];
  logic [AW-1:0]   rd_p0;
  logic            wr_en_p1;

  function automatic logic [n-1:0] rf_read(input logic [AW-1:0] addr);
`ifdef ALU_SEQ_ZERO_REG_EN
    if (addr == '0) return '0;
`endif
    return rf[addr];
  endfunction

  assign instr_ready = (state == IDLE);

`ifdef ALU_SEQ_ZERO_REG_EN
  assign wr_en_p1 = (alu_op != OP_ILLEGAL) && (rd_p0 != '0);
`else
  assign wr_en_p1 = (alu_op != OP_ILLEGAL);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
      alu_r2    <= '0;
      alu_r3    <= '0;
      alu_op    <= '0;
      rd_p0     <= '0;
      done      <= 1'b0;
      done_rd   <= '0;
      done_data <= '0;
      illegal   <= 1'b0;
      carry     <= 1'b0;
      dbg_data  <= '0;
    end else begin
      done     <= 1'b0;
      illegal  <= 1'b0;
      // Sampled before any same-edge writeback, so a colliding write shows up one cycle later.
      dbg_data <= rf_read(dbg_addr);
      case (state)
        IDLE: begin
          // p0: operands and op launched toward the ALU
          if (instr_valid) begin
            alu_op <= instr_op;
            alu_r2 <= rf_read(instr_rs);
            alu_r3 <= rf_read(instr_rt);
            rd_p0  <= instr_rd;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // p1: ALU result retired into the register file
          if (wr_en_p1) rf[rd_p0] <= alu_r1;
          if (alu_op == OP_ADD) carry <= alu_c_out;
          if (alu_op == OP_SUB) carry <= alu_c_out2;
          done      <= 1'b1;
          done_rd   <= rd_p0;
          done_data <= alu_r1;
          illegal   <= (alu_op == OP_ILLEGAL);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus a register-file/carry reference model,
// directed scenarios followed by randomized instruction streams.
module tb_alu_op_sequencer;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0, instr_rs = '0, instr_rt = '0;
  logic [N-1:0]  alu_r2, alu_r3, alu_r1;
  logic [2:0]    alu_op;
  logic          alu_c_out, alu_c_out2;
  logic          done, illegal, carry;
  logic [AW-1:0] done_rd;
  logic [N-1:0]  done_data, dbg_data;
  logic [AW-1:0] dbg_addr = '0;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] mrf [8];
  logic         mcarry;

  alu_op_sequencer #(.n(N), .REGS(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_op(alu_op),
    .alu_r1(alu_r1), .alu_c_out(alu_c_out), .alu_c_out2(alu_c_out2),
    .done(done), .done_rd(done_rd), .done_data(done_data), .illegal(illegal),
    .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] op_result(input logic [2:0] op, input logic [N-1:0] a, b);
    case (op)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return N'(int'(a) + int'(b));
      3'd3: return N'(int'(a) - int'(b));
      3'd4: return a | b;
      3'd5: return a & b;
      3'd6: return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      default: return a ^ b;
    endcase
  endfunction

  // External ALU stand-in
  logic [N:0] sum_w, dif_w;
  always_comb begin
    sum_w      = {1'b0, alu_r2} + {1'b0, alu_r3};
    dif_w      = {1'b0, alu_r2} + {1'b0, ~alu_r3} + 1'b1;
    alu_c_out  = sum_w[N];
    alu_c_out2 = dif_w[N];
    alu_r1     = op_result(alu_op, alu_r2, alu_r3);
  end

  function automatic logic [N-1:0] mread(input logic [AW-1:0] a);
`ifdef ALU_SEQ_ZERO_REG_EN
    if (a == 0) return '0;
`endif
    return mrf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    mcarry = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rs, rt);
    logic [N-1:0] a, b, r, old_rd;
    logic c;
    a = mread(rs);
    b = mread(rt);
    r = op_result(op, a, b);
    c = mcarry;
    if (op == 3'd2) c = (int'(a) + int'(b)) > 255;
    if (op == 3'd3) c = (a >= b);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rs = 3'($urandom); instr_rt = 3'($urandom);
    chk("ready_exec", instr_ready, 0);
    chk("done_exec", done, 0);
    chk("alu_op", alu_op, op);
    chk("alu_r2", alu_r2, a);
    chk("alu_r3", alu_r3, b);
    old_rd   = mread(rd);
    dbg_addr = rd;
    @(posedge clk); @(negedge clk);
    chk("done", done, 1);
    chk("done_rd", done_rd, rd);
    chk("done_data", done_data, r);
    chk("illegal", illegal, op == 3'd7);
    chk("dbg_prewrite", dbg_data, old_rd);
    if (op != 3'd7) begin
`ifdef ALU_SEQ_ZERO_REG_EN
      if (rd != 0) mrf[rd] = r;
`else
      mrf[rd] = r;
`endif
      if (op == 3'd2 || op == 3'd3) mcarry = c;
    end
    chk("carry", carry, mcarry);
  endtask

  task automatic check_dbg(input logic [AW-1:0] a);
    dbg_addr = a;
    @(posedge clk); @(negedge clk);
    chk("dbg", dbg_data, mread(a));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    do_reset();
    // Reset state
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_carry", carry, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_r2", alu_r2, 0);
    for (int i = 0; i < 8; i++) check_dbg(AW'(i));

    // Build r7=0xFF, r6=1, r2=0x20, r1=0xF0
    issue(3'd1, 3'd7, 3'd0, 3'd0);
    issue(3'd6, 3'd6, 3'd7, 3'd0);
    issue(3'd2, 3'd2, 3'd6, 3'd6);
    for (int i = 0; i < 4; i++) issue(3'd2, 3'd2, 3'd2, 3'd2);
    issue(3'd2, 3'd1, 3'd7, 3'd7);
    for (int i = 0; i < 3; i++) issue(3'd2, 3'd1, 3'd1, 3'd1);
    check_dbg(3'd1);
    chk("r1_const", dbg_data, 8'hF0);
    check_dbg(3'd2);
    chk("r2_const", dbg_data, 8'h20);

    // ADD with carry out
    issue(3'd2, 3'd3, 3'd1, 3'd2);
    chk("add_data", done_data, 8'h10);
    chk("add_carry", carry, 1);
    check_dbg(3'd3);
    chk("r3_const", dbg_data, 8'h10);

    // Back-to-back dependency: second accept lands in the done cycle of the first
    issue(3'd3, 3'd4, 3'd3, 3'd3);
    chk("sub_data", done_data, 8'h00);
    chk("sub_carry", carry, 1);
    issue(3'd1, 3'd5, 3'd4, 3'd0);
    chk("not_data", done_data, 8'hFF);

    // Illegal op leaves r6 and carry alone
    issue(3'd7, 3'd6, 3'd1, 3'd2);
    chk("illegal_flag", illegal, 1);
    check_dbg(3'd6);
    chk("r6_kept", dbg_data, 8'h01);
    chk("done_after", done, 0);

    // Reset during EXEC aborts the instruction
    instr_valid = 1'b1; instr_op = 3'd2; instr_rd = 3'd4; instr_rs = 3'd7; instr_rt = 3'd7;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_done", done, 0);
    rst = 1'b0;
    model_reset();
    chk("abort_ready", instr_ready, 1);
    chk("abort_carry", carry, 0);
    check_dbg(3'd4);
    chk("abort_done2", done, 0);

    // Register 0 behaviour
    issue(3'd1, 3'd5, 3'd0, 3'd0);
    issue(3'd0, 3'd0, 3'd5, 3'd0);
    chk("mov_r0_data", done_data, 8'hFF);
    check_dbg(3'd0);
`ifdef ALU_SEQ_ZERO_REG_EN
    chk("r0_zero", dbg_data, 8'h00);
`else
    chk("r0_plain", dbg_data, 8'hFF);
`endif

    // Randomized instruction stream with idle gaps and debug probes
    for (int k = 0; k < 300; k++) begin
      issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) check_dbg(3'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) check_dbg(AW'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
